// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch/countdown timer slice.
// Contents: FSM state type, BCD digit width and moduli, default up-count
// limit, and BCD helper functions used for load saturation and for
// precomputing the value one second before the up-count limit.
package timer_pkg;

  localparam int          DIGIT_W          = 4;
  localparam logic [3:0]  SEC_ONES_MAX     = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX     = 4'd5;
  localparam logic [15:0] DEFAULT_UP_LIMIT = 16'h5959;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timerState_t;

  // Clamp one BCD digit to its largest legal value.
  function automatic logic [DIGIT_W-1:0] satDigit(input logic [DIGIT_W-1:0] d,
                                                  input logic [DIGIT_W-1:0] maxVal);
    return (d > maxVal) ? maxVal : d;
  endfunction

  // Clamp a packed {minTens, minOnes, secTens, secOnes} value digit by digit.
  function automatic logic [15:0] satBcd(input logic [15:0] v);
    return {satDigit(v[15:12], SEC_TENS_MAX), satDigit(v[11:8], SEC_ONES_MAX),
            satDigit(v[7:4],   SEC_TENS_MAX), satDigit(v[3:0],  SEC_ONES_MAX)};
  endfunction

  // One-second BCD decrement with borrow rippling from secOnes upward.
  function automatic logic [15:0] bcdPred(input logic [15:0] v);
    logic [15:0]        res;
    logic               borrow;
    logic [DIGIT_W-1:0] dig;
    logic [DIGIT_W-1:0] maxVal;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      maxVal = (i % 2 == 0) ? SEC_ONES_MAX : SEC_TENS_MAX;
      dig    = v[i*4 +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = maxVal;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      res[i*4 +: 4] = dig;
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_core_if.sv
// Control/status bundle between the timer core and its surroundings.
// master: drives tick, control pulses, load value and direction; reads the
//         BCD count and status flags.
// slave:  the timer core itself.
interface timer_core_if;
  logic        tickIn;
  logic        startStop;
  logic        clear;
  logic        load;
  logic [15:0] loadValue;
  logic        countDown;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        pauseOut;

  modport master (
    output tickIn, startStop, clear, load, loadValue, countDown,
    input  digits, running, expired, pauseOut
  );

  modport slave (
    input  tickIn, startStop, clear, load, loadValue, countDown,
    output digits, running, expired, pauseOut
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous clear, saturating load and up/down step.
// Ports:
//   inputClock, nReset  clock and asynchronous active-low reset
//   i_clear             force digit to 0 (highest priority)
//   i_load, i_loadValue load digit, clamped to MAX
//   i_inc, i_dec        step up / down, wrapping at MAX / 0
//   o_value             current digit
//   o_carry, o_borrow   step request that wraps this digit, for the next digit
//   o_isZero            terminal value when counting down
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = SEC_ONES_MAX
) (
  input  logic               inputClock,
  input  logic               nReset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_loadValue,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [DIGIT_W-1:0] o_value,
  output logic               o_carry,
  output logic               o_borrow,
  output logic               o_isZero
);

  logic [DIGIT_W-1:0] r_value;
  logic               w_isMax;

  assign w_isMax  = (r_value == MAX);
  assign o_isZero = (r_value == '0);
  assign o_carry  = i_inc & w_isMax;
  assign o_borrow = i_dec & o_isZero;
  assign o_value  = r_value;

  always_ff @(posedge inputClock or negedge nReset) begin
    if (!nReset) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= satDigit(i_loadValue, MAX);
    end else if (i_inc) begin
      r_value <= w_isMax ? '0 : r_value + 4'd1;
    end else if (i_dec) begin
      r_value <= o_isZero ? MAX : r_value - 4'd1;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Stopwatch/countdown core: turns each rising edge of the divided tick into
// one second of a BCD MM:SS count and runs the IDLE/RUN/PAUSE/DONE machine.
// Ports:
//   inputClock, nReset  system clock and asynchronous active-low reset
//   bus (slave)         tickIn, startStop, clear, load, loadValue, countDown in;
//                       digits, running, expired, pauseOut out
module timer_core
  import timer_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] UP_LIMIT    = DEFAULT_UP_LIMIT
) (
  input logic         inputClock,
  input logic         nReset,
  timer_core_if.slave bus
);

  localparam logic [15:0] UP_PRED = bcdPred(UP_LIMIT);

  timerState_t            r_state;
  timerState_t            w_nextState;
  logic                   r_countDown;
  logic                   r_running;
  logic                   r_expired;
  logic                   r_pauseOut;
  logic                   r_ssPrev;
  logic                   r_clearPrev;
  logic                   r_loadPrev;
  logic [SYNC_STAGES-1:0] r_tickSync;
  logic                   r_tickHist;

  logic        w_ssEvent;
  logic        w_clearEvent;
  logic        w_loadEvent;
  logic        w_tickEvent;
  logic        w_loadAccept;
  logic        w_tickStep;
  logic        w_latchDir;
  logic        w_wrap;
  logic        w_countZero;
  logic [3:0]  w_isZero;
  logic [4:0]  w_inc;
  logic [4:0]  w_dec;
  logic [15:0] w_digits;
  logic [15:0] w_startCount;

  // Input history and tick synchroniser; the extra history flop turns the
  // synchronised level into a single-cycle tick event.
  always_ff @(posedge inputClock or negedge nReset) begin
    if (!nReset) begin
      r_ssPrev    <= 1'b0;
      r_clearPrev <= 1'b0;
      r_loadPrev  <= 1'b0;
      r_tickSync  <= '0;
      r_tickHist  <= 1'b0;
    end else begin
      r_ssPrev    <= bus.startStop;
      r_clearPrev <= bus.clear;
      r_loadPrev  <= bus.load;
      r_tickSync  <= {r_tickSync[SYNC_STAGES-2:0], bus.tickIn};
      r_tickHist  <= r_tickSync[SYNC_STAGES-1];
    end
  end

  assign w_ssEvent    = bus.startStop & ~r_ssPrev;
  assign w_clearEvent = bus.clear & ~r_clearPrev;
  assign w_loadEvent  = bus.load & ~r_loadPrev;
  assign w_tickEvent  = r_tickSync[SYNC_STAGES-1] & ~r_tickHist;

  assign w_loadAccept = w_loadEvent & ~w_clearEvent & ((r_state == IDLE) | (r_state == PAUSE));
  // A startStop in the same cycle as a tick wins and the tick is dropped.
  assign w_tickStep   = w_tickEvent & ~w_ssEvent & ~w_clearEvent & (r_state == RUN);
  assign w_countZero  = &w_isZero;
  // Never step past the end values, so a count loaded at a limit cannot wrap.
  assign w_inc[0]     = w_tickStep & ~r_countDown & (w_digits != UP_LIMIT);
  assign w_dec[0]     = w_tickStep & r_countDown & ~w_countZero;
  assign w_wrap       = w_inc[4] | w_dec[4];
  // A load coinciding with startStop in IDLE decides whether the run starts.
  assign w_startCount = w_loadAccept ? satBcd(bus.loadValue) : w_digits;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit_counter #(
      .MAX((g % 2 == 0) ? SEC_ONES_MAX : SEC_TENS_MAX)
    ) u_digit (
      .inputClock  (inputClock),
      .nReset      (nReset),
      .i_clear     (w_clearEvent),
      .i_load      (w_loadAccept),
      .i_loadValue (bus.loadValue[g*4 +: 4]),
      .i_inc       (w_inc[g]),
      .i_dec       (w_dec[g]),
      .o_value     (w_digits[g*4 +: 4]),
      .o_carry     (w_inc[g+1]),
      .o_borrow    (w_dec[g+1]),
      .o_isZero    (w_isZero[g])
    );
  end

  // Next-state logic. DONE is entered on the tick that writes the final value,
  // so the check looks at the value one step before the end.
  always_comb begin
    w_nextState = r_state;
    w_latchDir  = 1'b0;
    if (w_clearEvent) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ssEvent) begin
            w_latchDir = 1'b1;
            if (!(bus.countDown && (w_startCount == 16'h0000))) begin
              w_nextState = RUN;
            end
          end
        end
        RUN: begin
          if (w_ssEvent) begin
            w_nextState = PAUSE;
          end else if (w_tickEvent) begin
            if (r_countDown) begin
              if (w_countZero || (w_digits == 16'h0001)) w_nextState = DONE;
            end else begin
              if ((w_digits == UP_PRED) || (w_digits == UP_LIMIT)) w_nextState = DONE;
            end
            if (w_wrap) w_nextState = DONE;
          end
        end
        PAUSE: begin
          if (w_ssEvent) w_nextState = RUN;
        end
        DONE: begin
          if (w_ssEvent) w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register; status outputs are registered from the next state so
  // they carry no combinational path from the inputs.
  always_ff @(posedge inputClock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_countDown <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_pauseOut  <= 1'b1;
    end else begin
      r_state     <= w_nextState;
      if (w_latchDir) r_countDown <= bus.countDown;
      r_running   <= (w_nextState == RUN);
      r_expired   <= (w_nextState == DONE);
      r_pauseOut  <= (w_nextState != RUN);
    end
  end

  assign bus.digits   = w_digits;
  assign bus.running  = r_running;
  assign bus.expired  = r_expired;
  assign bus.pauseOut = r_pauseOut;

endmodule
